fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction fetch sequencer that drives the `decoder` block. Reads 32-bit words from the instruction memory port, presents each instruction to the decoder, and streams the trailing 64-bit immediate (two words) whenever the instruction carries one. Handles backend stall and PC redirect (branch/trap).

## Interface

Parameters:
- `DATA_W`, 64, immediate width; fixed at 2×`INST_W`.
- `INST_W`, 32, instruction/memory word width.
- `ADDR_W`, 64, byte address width.
- `RESET_PC`, 0, first fetch address after reset.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `mem_req`  out  1  fetch request; held until `mem_ack`.
- `mem_addr`  out  `ADDR_W`  byte address of requested word; stable while `mem_req`.
- `mem_ack`  in  1  `mem_rdata` valid this cycle; ignored unless `mem_req`=1.
- `mem_rdata`  in  `INST_W`  fetched word.
- `inst`  out  `INST_W`  instruction to decoder `inst`.
- `inst_valid`  out  1  `inst` transferred this cycle.
- `imm_out`  out  `DATA_W`  immediate to decoder `imm_in`.
- `imm_valid`  out  1  drives decoder `imm_in_en`.
- `pc`  out  `ADDR_W`  address of instruction in `inst`.
- `stall`  in  1  backend cannot accept; blocks transfers.
- `redirect`  in  1  flush and restart fetch.
- `redirect_pc`  in  `ADDR_W`  new fetch address; word-aligned.
- `busy`  out  1  high in every state except BOOT.

## Operation

- States: BOOT, FETCH_INST, ISSUE, FETCH_LO, FETCH_HI, ISSUE_IMM.
- Registers: `fpc` (fetch address), `pc`, `inst`, `imm_out`, state.
- `mem_req` = state ∈ {FETCH_INST, FETCH_LO, FETCH_HI}; `mem_addr` = `fpc`.
- BOOT → FETCH_INST unconditionally (one cycle).
- FETCH_INST: on `mem_ack`, `inst`←`mem_rdata`, `pc`←`fpc`, `fpc`←`fpc`+4, → ISSUE.
- ISSUE: `inst_valid` = !`stall`. On !`stall`: if `inst[31:20]` ≥ 12'h100 and `inst[0]`=1 → FETCH_LO, else → FETCH_INST. On `stall`: hold.
- FETCH_LO: on `mem_ack`, `imm_out[31:0]`←`mem_rdata`, `fpc`+=4, → FETCH_HI.
- FETCH_HI: on `mem_ack`, `imm_out[63:32]`←`mem_rdata`, `fpc`+=4, → ISSUE_IMM.
- ISSUE_IMM: `imm_valid` = !`stall`; on !`stall` → FETCH_INST; else hold.
- Immediate is little-endian: low word at lower address.
- ALU-class opcodes (< 12'h100) never fetch an immediate regardless of `inst[0]`.
- `redirect` (any state except BOOT, highest priority): `fpc`←`redirect_pc`, → FETCH_INST; `inst_valid`/`imm_valid` forced 0 that cycle; a `mem_ack` in the same cycle is discarded; partial immediate discarded.
- `fpc` arithmetic is modulo 2^`ADDR_W`; wrap from all-ones-minus-3 to 0 is silent.

## Timing

- Reset (async assert): state=BOOT, `fpc`=`RESET_PC`, `pc`=0, `inst`=0, `imm_out`=0; `mem_req`=0, `inst_valid`=0, `imm_valid`=0, `busy`=0, `mem_addr`=`RESET_PC`.
- First `mem_req` the second rising edge after reset release (BOOT lasts one cycle).
- Zero-wait memory (`mem_ack` same cycle as `mem_req`): plain instruction every 2 cycles; immediate instruction 5 cycles (FETCH, ISSUE, LO, HI, ISSUE_IMM).
- `inst_valid` and `imm_valid` are combinational from state and `stall`; `inst`, `imm_out`, `pc` are registered and stable throughout ISSUE/ISSUE_IMM.
- `inst_valid` and `imm_valid` never high in the same cycle; each is high for exactly one cycle per transfer.
- Reset asserted mid-fetch: outstanding request abandoned; memory must tolerate dropped `mem_req`.
- `redirect` with `stall`: redirect wins.

## Test plan

- Reset release, zero-wait memory, word at 0 = 32'h0050_0010 (ALU op) → `mem_req` at cycle 2 addr 0, `inst_valid` cycle 3, next `mem_req` addr 4 cycle 4.
- Word 32'h1000_0011 (LOAD, flag0) then 32'hDEAD_BEEF, 32'h0123_4567 → `inst_valid` once, then `imm_valid` with `imm_out`=64'h0123_4567_DEAD_BEEF, next fetch addr 12.
- Word 32'h0020_0001 (ALU, flag0 set) → no immediate fetch; next fetch addr 4.
- `stall` high 3 cycles in ISSUE → `inst_valid`=0, `inst`/`pc` stable; `inst_valid` in cycle `stall` drops.
- `redirect`=1, `redirect_pc`=64'h400 in FETCH_HI with `mem_ack`=1 → no `imm_valid`; next cycle `mem_req` addr 64'h400.
- Memory with 3-cycle ack latency → `mem_req`/`mem_addr` stable for all 3 cycles; `rst` asserted in cycle 2 → outputs at reset values immediately.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer feeding the decoder.
// Fetches one 32-bit instruction word. If the instruction carries a 64-bit
// immediate, it then fetches two more words (low word first) and presents the
// immediate on a separate transfer. Backend stall and PC redirect are handled.
module fetch_ctrl #(
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       DATA_W   = 2 * INST_W,
  parameter int unsigned       ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic [DATA_W-1:0] imm_out,
  output logic              imm_valid,
  output logic [ADDR_W-1:0] pc,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH_INST,
    S_ISSUE,
    S_FETCH_LO,
    S_FETCH_HI,
    S_ISSUE_IMM
  } state_t;

  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_fpc;
  logic [ADDR_W-1:0] w_fpc_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [INST_W-1:0] r_inst;
  logic [INST_W-1:0] w_inst_nxt;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] w_imm_nxt;
  logic [ADDR_W-1:0] w_fpc_inc;
  logic              w_redirect;
  logic              w_has_imm;

  // Fetch address increments wrap silently modulo 2^ADDR_W.
  assign w_fpc_inc  = r_fpc + WORD_BYTES;
  // Redirect is not honoured during the single BOOT cycle.
  assign w_redirect = redirect && (r_state != S_BOOT);
  // Non-ALU opcode class with flag bit 0 set carries a trailing immediate.
  assign w_has_imm  = (r_inst[31:20] >= 12'h100) && r_inst[0];

  assign mem_addr = r_fpc;
  assign inst     = r_inst;
  assign imm_out  = r_imm;
  assign pc       = r_pc;
  assign busy     = (r_state != S_BOOT);

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_BOOT;
      r_fpc   <= RESET_PC;
      r_pc    <= '0;
      r_inst  <= '0;
      r_imm   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fpc   <= w_fpc_nxt;
      r_pc    <= w_pc_nxt;
      r_inst  <= w_inst_nxt;
      r_imm   <= w_imm_nxt;
    end
  end

  // Next-state, datapath updates and handshake outputs; redirect overrides all.
  always_comb begin
    w_state_nxt = r_state;
    w_fpc_nxt   = r_fpc;
    w_pc_nxt    = r_pc;
    w_inst_nxt  = r_inst;
    w_imm_nxt   = r_imm;
    mem_req     = 1'b0;
    inst_valid  = 1'b0;
    imm_valid   = 1'b0;

    case (r_state)
      S_BOOT: begin
        w_state_nxt = S_FETCH_INST;
      end
      S_FETCH_INST: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          w_inst_nxt  = mem_rdata;
          w_pc_nxt    = r_fpc;
          w_fpc_nxt   = w_fpc_inc;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        inst_valid = !stall;
        if (!stall) begin
          w_state_nxt = w_has_imm ? S_FETCH_LO : S_FETCH_INST;
        end
      end
      S_FETCH_LO: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          w_imm_nxt   = {r_imm[DATA_W-1:INST_W], mem_rdata};
          w_fpc_nxt   = w_fpc_inc;
          w_state_nxt = S_FETCH_HI;
        end
      end
      S_FETCH_HI: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          w_imm_nxt   = {mem_rdata, r_imm[INST_W-1:0]};
          w_fpc_nxt   = w_fpc_inc;
          w_state_nxt = S_ISSUE_IMM;
        end
      end
      S_ISSUE_IMM: begin
        imm_valid = !stall;
        if (!stall) begin
          w_state_nxt = S_FETCH_INST;
        end
      end
      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase

    // Redirect discards any same-cycle ack data and any partial immediate.
    if (w_redirect) begin
      w_state_nxt = S_FETCH_INST;
      w_fpc_nxt   = redirect_pc;
      w_pc_nxt    = r_pc;
      w_inst_nxt  = r_inst;
      w_imm_nxt   = r_imm;
      inst_valid  = 1'b0;
      imm_valid   = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed timing scenarios followed by randomized
// stall/redirect/latency traffic checked against a transfer-stream model.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [63:0] imm_out;
  logic        imm_valid;
  logic [63:0] pc;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        busy;

  int unsigned checks;
  int unsigned failures;

  fetch_ctrl #(
    .INST_W  (32),
    .DATA_W  (64),
    .ADDR_W  (64),
    .RESET_PC(64'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .inst       (inst),
    .inst_valid (inst_valid),
    .imm_out    (imm_out),
    .imm_valid  (imm_valid),
    .pc         (pc),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 64-word memory image; addresses alias modulo 256 bytes.
  logic [31:0] mem [64];
  int unsigned m_cnt;
  int unsigned m_lat;
  bit          m_rand_lat;

  function automatic logic [31:0] mem_at(input logic [63:0] a);
    return mem[a[7:2]];
  endfunction

  function automatic bit carries_imm(input logic [31:0] w);
    return (w[31:20] >= 12'h100) && w[0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory responder: acks after m_lat wait cycles, garbage data otherwise.
  always @(negedge clk) begin
    if (mem_req) begin
      if (m_cnt >= m_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr[7:2]];
        m_cnt     = 0;
        if (m_rand_lat) m_lat = $urandom_range(0, 2);
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        m_cnt++;
      end
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      m_cnt     = 0;
    end
  end

  // Drive backend inputs for the next cycle, then sample 1 time unit later.
  task automatic tick(input bit s, input bit r, input logic [63:0] rpc);
    @(negedge clk);
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},  {63'd0, mem_req},    64'd0);
    chk({tag, "_addr"}, mem_addr,            64'd0);
    chk({tag, "_iv"},   {63'd0, inst_valid}, 64'd0);
    chk({tag, "_mv"},   {63'd0, imm_valid},  64'd0);
    chk({tag, "_busy"}, {63'd0, busy},       64'd0);
    chk({tag, "_pc"},   pc,                  64'd0);
    chk({tag, "_inst"}, {32'd0, inst},       64'd0);
    chk({tag, "_imm"},  imm_out,             64'd0);
  endtask

  // Random-phase model state: next expected transfer starts at exp_p.
  logic [63:0] exp_p;
  bit          pend_imm;
  bit          prev_req;
  bit          prev_ack;
  bit          prev_redir;
  logic [63:0] prev_addr;
  int unsigned idle;
  logic [63:0] rpc;
  bit          s_r;
  bit          r_r;

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b0;
    stall      = 1'b0;
    redirect   = 1'b0;
    redirect_pc = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    m_cnt      = 0;
    m_lat      = 0;
    m_rand_lat = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000;
    mem[0] = 32'h0050_0010;
    mem[1] = 32'h1000_0011;
    mem[2] = 32'hDEAD_BEEF;
    mem[3] = 32'h0123_4567;
    mem[4] = 32'h0020_0001;
    mem[5] = 32'h1000_0011;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals("rst");

    // Release: BOOT cycle, then first request
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("boot_req",  {63'd0, mem_req}, 64'd0);
    chk("boot_busy", {63'd0, busy},    64'd0);
    tick(0, 0, '0);
    chk("f0_req",  {63'd0, mem_req}, 64'd1);
    chk("f0_addr", mem_addr,         64'd0);
    chk("f0_busy", {63'd0, busy},    64'd1);
    tick(0, 0, '0);
    chk("i0_iv",   {63'd0, inst_valid}, 64'd1);
    chk("i0_inst", {32'd0, inst},       64'h0050_0010);
    chk("i0_pc",   pc,                  64'd0);
    // Immediate-carrying instruction at 4
    tick(0, 0, '0);
    chk("f1_addr", mem_addr, 64'd4);
    tick(0, 0, '0);
    chk("i1_iv",   {63'd0, inst_valid}, 64'd1);
    chk("i1_inst", {32'd0, inst},       64'h1000_0011);
    chk("i1_pc",   pc,                  64'd4);
    tick(0, 0, '0);
    chk("lo_addr", mem_addr,            64'd8);
    chk("lo_iv",   {63'd0, inst_valid}, 64'd0);
    tick(0, 0, '0);
    chk("hi_addr", mem_addr, 64'd12);
    tick(0, 0, '0);
    chk("im_mv",  {63'd0, imm_valid},  64'd1);
    chk("im_iv",  {63'd0, inst_valid}, 64'd0);
    chk("im_val", imm_out,             64'h0123_4567_DEAD_BEEF);
    tick(0, 0, '0);
    chk("f2_req",  {63'd0, mem_req}, 64'd1);
    chk("f2_addr", mem_addr,         64'd16);
    // ALU op with flag set, stalled three cycles
    for (int k = 0; k < 3; k++) begin
      tick(1, 0, '0);
      chk("st_iv",   {63'd0, inst_valid}, 64'd0);
      chk("st_inst", {32'd0, inst},       64'h0020_0001);
      chk("st_pc",   pc,                  64'd16);
    end
    tick(0, 0, '0);
    chk("st_rel_iv", {63'd0, inst_valid}, 64'd1);
    tick(0, 0, '0);
    chk("alu_noimm", mem_addr, 64'd20);
    // Redirect during FETCH_HI with ack
    tick(0, 0, '0);
    chk("i3_iv", {63'd0, inst_valid}, 64'd1);
    tick(0, 0, '0);
    chk("lo2_addr", mem_addr, 64'd24);
    tick(0, 1, 64'h400);
    chk("rd_addr", mem_addr,            64'd28);
    chk("rd_ack",  {63'd0, mem_ack},    64'd1);
    chk("rd_mv",   {63'd0, imm_valid},  64'd0);
    m_lat = 2;
    tick(0, 0, '0);
    chk("rd_req",  {63'd0, mem_req},   64'd1);
    chk("rd_new",  mem_addr,           64'h400);
    chk("rd_mv2",  {63'd0, imm_valid}, 64'd0);
    // Slow memory: request held, then reset mid-request
    tick(0, 0, '0);
    chk("sl_req",  {63'd0, mem_req}, 64'd1);
    chk("sl_addr", mem_addr,         64'h400);
    chk("sl_inst", {32'd0, inst},    64'h1000_0011);
    rst = 1'b0;
    #1;
    chk_reset_vals("arst");

    // Randomized phase
    for (int i = 0; i < 64; i++) begin
      case ($urandom_range(0, 2))
        0: mem[i] = {12'($urandom_range(12'h100, 12'hFFF)), 19'($urandom), 1'b1};
        1: mem[i] = {12'($urandom_range(0, 12'h0FF)), 20'($urandom)};
        default: mem[i] = $urandom;
      endcase
    end
    m_rand_lat = 1'b1;
    m_lat      = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_p      = 64'h0;
    pend_imm   = 1'b0;
    prev_req   = 1'b0;
    prev_ack   = 1'b0;
    prev_redir = 1'b0;
    prev_addr  = '0;
    idle       = 0;
    for (int i = 0; i < 3000; i++) begin
      s_r = ($urandom_range(0, 3) == 0);
      r_r = (i >= 2) && ($urandom_range(0, 19) == 0);
      rpc = (($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FF00 : 64'h0)
            | {56'd0, 6'($urandom_range(0, 63)), 2'b00};
      if (i == 1000) begin
        r_r = 1'b1;
        rpc = 64'hFFFF_FFFF_FFFF_FFF8;
      end
      tick(s_r, r_r, rpc);
      if (inst_valid && imm_valid) chk("excl", 64'd1, 64'd0);
      if ((stall || redirect) && (inst_valid || imm_valid))
        chk("blocked", {62'd0, inst_valid, imm_valid}, 64'd0);
      if (prev_req && !prev_ack && !prev_redir) begin
        chk("hold_req",  {63'd0, mem_req}, 64'd1);
        chk("hold_addr", mem_addr,         prev_addr);
      end
      if (inst_valid) begin
        chk("ord_inst", {63'd0, pend_imm}, 64'd0);
        chk("r_inst",   {32'd0, inst},     {32'd0, mem_at(exp_p)});
        chk("r_pc",     pc,                exp_p);
        if (carries_imm(mem_at(exp_p))) pend_imm = 1'b1;
        else exp_p = exp_p + 64'd4;
        idle = 0;
      end
      if (imm_valid) begin
        chk("ord_imm", {63'd0, pend_imm}, 64'd1);
        chk("r_imm", imm_out, {mem_at(exp_p + 64'd8), mem_at(exp_p + 64'd4)});
        exp_p    = exp_p + 64'd12;
        pend_imm = 1'b0;
        idle     = 0;
      end
      if (redirect) begin
        exp_p    = redirect_pc;
        pend_imm = 1'b0;
      end
      prev_req   = mem_req;
      prev_ack   = mem_ack;
      prev_redir = redirect;
      prev_addr  = mem_addr;
      idle++;
      if (idle > 200) begin
        chk("timeout", 64'(idle), 64'd200);
        break;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
